mips_multicycle_ctrl: RTL and testbench

Multi-cycle control FSM that sequences the MIPS datapath (PC, instruction register, ALU, unified memory, 32x32 register file). It decodes opcode and funct and drives every datapath strobe, including the register-file RegRead/RegWrite enables. The register file samples reads on negedge and writes on posedge while its enable is high. Memory accesses use a ready handshake with a bounded wait; on timeout or an unsupported opcode the FSM traps.

---
 rtl/mips_multicycle_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences PC/IR/ALU/memory/register-file strobes with bounded memory waits and a sticky trap.
// Optional retired-instruction counter enabled by defining MIPS_CTRL_RETIRE_CNT_EN.
module mips_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegRead,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       trap,
  output logic [1:0] trap_cause
`ifdef MIPS_CTRL_RETIRE_CNT_EN
  ,
  output logic [31:0] retired
`endif
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_RD    = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WR    = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    ADDI_EXEC = 4'd10,
    ADDI_WB   = 4'd11,
    TRAP      = 4'd12
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt;
  logic               timeout;
  logic               wait_now, wait_next;

  // funct is decoded by the ALU control and zero gates PCWriteCond in the datapath
  logic unused_inputs;
  assign unused_inputs = ^{funct, zero};

  assign state     = state_q;
  assign wait_now  = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
  assign wait_next = (state_d == FETCH) || (state_d == MEM_RD) || (state_d == MEM_WR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FETCH;
      wait_cnt   <= '0;
      trap       <= 1'b0;
      trap_cause <= 2'b00;
    end else begin
      state_q <= state_d;
      if (wait_next && (state_d != state_q))
        wait_cnt <= '0;
      else if (wait_now && !mem_ready)
        wait_cnt <= wait_cnt + 1'b1;
      if ((state_d == TRAP) && (state_q != TRAP)) begin
        trap       <= 1'b1;
        trap_cause <= timeout ? 2'b10 : 2'b01;
      end
    end
  end

`ifdef MIPS_CTRL_RETIRE_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      retired <= '0;
    else if ((state_d == FETCH) &&
             ((state_q == MEM_WB) || (state_q == MEM_WR) || (state_q == R_WB) ||
              (state_q == BRANCH) || (state_q == JUMP) || (state_q == ADDI_WB)))
      retired <= retired + 32'd1;
  end
`endif

  always_comb begin
    state_d = state_q;
    timeout = 1'b0;
    case (state_q)
      FETCH: begin
        if (mem_ready) state_d = DECODE;
        else if (wait_cnt == CNT_W'(MEM_TIMEOUT)) begin
          state_d = TRAP;
          timeout = 1'b1;
        end
      end
      DECODE: begin
        case (opcode)
          6'b000000:           state_d = R_EXEC;
          6'b100011, 6'b101011: state_d = MEM_ADDR;
          6'b000100:           state_d = BRANCH;
          6'b000010:           state_d = JUMP;
          6'b001000:           state_d = ADDI_EXEC;
          default:             state_d = TRAP;
        endcase
      end
      MEM_ADDR:  state_d = (opcode == 6'b100011) ? MEM_RD : MEM_WR;
      MEM_RD: begin
        if (mem_ready) state_d = MEM_WB;
        else if (wait_cnt == CNT_W'(MEM_TIMEOUT)) begin
          state_d = TRAP;
          timeout = 1'b1;
        end
      end
      MEM_WR: begin
        if (mem_ready) state_d = FETCH;
        else if (wait_cnt == CNT_W'(MEM_TIMEOUT)) begin
          state_d = TRAP;
          timeout = 1'b1;
        end
      end
      MEM_WB:    state_d = FETCH;
      R_EXEC:    state_d = R_WB;
      R_WB:      state_d = FETCH;
      BRANCH:    state_d = FETCH;
      JUMP:      state_d = FETCH;
      ADDI_EXEC: state_d = ADDI_WB;
      ADDI_WB:   state_d = FETCH;
      TRAP:      state_d = TRAP;
      default:   state_d = TRAP;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegRead     = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    if (!reset) begin
      case (state_q)
        FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        DECODE: begin
          RegRead = 1'b1;
          ALUSrcB = 2'b11;
        end
        MEM_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        MEM_RD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        MEM_WB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        MEM_WR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        R_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        R_WB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
        end
        JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
        end
        ADDI_EXEC: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        ADDI_WB:   RegWrite = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: expected state/strobes queued per driven cycle, compared at negedge.
module tb_mips_multicycle_ctrl;

  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2, MEM_RD = 4'd3, MEM_WB = 4'd4,
    MEM_WR = 4'd5, R_EXEC = 4'd6, R_WB = 4'd7, BRANCH = 4'd8, JUMP = 4'd9,
    ADDI_EXEC = 4'd10, ADDI_WB = 4'd11, TRAP = 4'd12
  } st_t;

  typedef struct {
    logic [3:0]  st;
    logic [16:0] ctl;
    logic        trp;
    logic [1:0]  cause;
  } item_t;

  logic clk = 1'b0;
  logic reset, zero, mem_ready;
  logic [5:0] opcode, funct;
  logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst;
  logic RegRead, RegWrite, ALUSrcA, trap;
  logic [1:0] ALUSrcB, ALUOp, PCSource, trap_cause;
  logic [3:0] state;
`ifdef MIPS_CTRL_RETIRE_CNT_EN
  logic [31:0] retired;
`endif

  int vectors = 0;
  int miscompares = 0;
  item_t sb[$];

  mips_multicycle_ctrl #(.MEM_TIMEOUT(15), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
    .RegDst(RegDst), .RegRead(RegRead), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .state(state),
    .trap(trap), .trap_cause(trap_cause)
`ifdef MIPS_CTRL_RETIRE_CNT_EN
    , .retired(retired)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg RegDst RegRead RegWrite ALUSrcA ALUSrcB ALUOp PCSource
  function automatic logic [16:0] model_ctl(input logic [3:0] st, input logic rdy, input logic rst);
    if (rst) return '0;
    case (st)
      FETCH:     return {rdy, 1'b0, 1'b0, 1'b1, 1'b0, rdy, 4'b0000, 1'b0, 2'b01, 2'b00, 2'b00};
      DECODE:    return {8'b0, 1'b1, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00};
      MEM_ADDR:  return {10'b0, 1'b1, 2'b10, 2'b00, 2'b00};
      MEM_RD:    return {2'b00, 1'b1, 1'b1, 7'b0, 6'b0};
      MEM_WB:    return {6'b0, 1'b1, 2'b00, 1'b1, 1'b0, 6'b0};
      MEM_WR:    return {2'b00, 1'b1, 1'b0, 1'b1, 6'b0, 6'b0};
      R_EXEC:    return {10'b0, 1'b1, 2'b00, 2'b10, 2'b00};
      R_WB:      return {7'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'b0};
      BRANCH:    return {1'b0, 1'b1, 8'b0, 1'b1, 2'b00, 2'b01, 2'b01};
      JUMP:      return {1'b1, 10'b0, 2'b00, 2'b00, 2'b10};
      ADDI_EXEC: return {10'b0, 1'b1, 2'b10, 2'b00, 2'b00};
      ADDI_WB:   return {9'b0, 1'b1, 7'b0};
      default:   return '0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      item_t it;
      it = sb.pop_front();
      check("state", {28'd0, state}, {28'd0, it.st});
      check("ctl", {15'd0, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                    RegDst, RegRead, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource},
            {15'd0, it.ctl});
      check("trap", {31'd0, trap}, {31'd0, it.trp});
      check("trap_cause", {30'd0, trap_cause}, {30'd0, it.cause});
      check("rd_wr_excl", {31'd0, RegRead & RegWrite}, 32'd0);
    end
  end

  // Drive one cycle of inputs and queue the outputs expected during that cycle.
  task automatic step(input logic rst, input logic [5:0] op, input logic rdy, input logic z,
                      input st_t st, input logic trp, input logic [1:0] cause);
    item_t it;
    reset = rst; opcode = op; mem_ready = rdy; zero = z; funct = 6'b100000;
    it.st = st; it.ctl = model_ctl(st, rdy, rst); it.trp = trp; it.cause = cause;
    sb.push_back(it);
    @(posedge clk); #1;
  endtask

  task automatic fetch(input logic [5:0] op);
    step(1'b0, op, 1'b1, 1'b0, FETCH, 1'b0, 2'b00);
    step(1'b0, op, 1'b0, 1'b0, DECODE, 1'b0, 2'b00);
  endtask

  task automatic run_rtype;
    fetch(6'b000000);
    step(1'b0, 6'b000000, 1'b0, 1'b0, R_EXEC, 1'b0, 2'b00);
    step(1'b0, 6'b000000, 1'b0, 1'b0, R_WB, 1'b0, 2'b00);
  endtask

  task automatic run_lw(input int waits);
    fetch(6'b100011);
    step(1'b0, 6'b100011, 1'b0, 1'b0, MEM_ADDR, 1'b0, 2'b00);
    for (int i = 0; i < waits; i++) step(1'b0, 6'b100011, 1'b0, 1'b0, MEM_RD, 1'b0, 2'b00);
    step(1'b0, 6'b100011, 1'b1, 1'b0, MEM_RD, 1'b0, 2'b00);
    step(1'b0, 6'b100011, 1'b0, 1'b0, MEM_WB, 1'b0, 2'b00);
  endtask

  task automatic run_sw;
    fetch(6'b101011);
    step(1'b0, 6'b101011, 1'b0, 1'b0, MEM_ADDR, 1'b0, 2'b00);
    step(1'b0, 6'b101011, 1'b1, 1'b0, MEM_WR, 1'b0, 2'b00);
  endtask

  task automatic run_j;
    fetch(6'b000010);
    step(1'b0, 6'b000010, 1'b0, 1'b0, JUMP, 1'b0, 2'b00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    step(1'b1, 6'b000000, 1'b0, 1'b0, FETCH, 1'b0, 2'b00);
`ifdef MIPS_CTRL_RETIRE_CNT_EN
    check("retired_reset", retired, 32'd0);
`endif

    run_rtype();
    run_lw(3);
    fetch(6'b000100);
    step(1'b0, 6'b000100, 1'b0, 1'b1, BRANCH, 1'b0, 2'b00);
    fetch(6'b001000);
    step(1'b0, 6'b001000, 1'b0, 1'b0, ADDI_EXEC, 1'b0, 2'b00);
    step(1'b0, 6'b001000, 1'b0, 1'b0, ADDI_WB, 1'b0, 2'b00);
    run_sw();
    run_j();

    // Illegal opcode: absorbing trap with cause 01 until reset
    fetch(6'b111111);
    for (int i = 0; i < 20; i++) step(1'b0, 6'b000000, 1'(i % 2), 1'b0, TRAP, 1'b1, 2'b01);
    step(1'b1, 6'b000000, 1'b0, 1'b0, TRAP, 1'b1, 2'b01);

    // Fetch timeout: 16 cycles without ready, then trap cause 10
    for (int i = 0; i < 16; i++) step(1'b0, 6'b000000, 1'b0, 1'b0, FETCH, 1'b0, 2'b00);
    step(1'b0, 6'b000000, 1'b0, 1'b0, TRAP, 1'b1, 2'b10);
    step(1'b0, 6'b000000, 1'b0, 1'b0, TRAP, 1'b1, 2'b10);
    step(1'b1, 6'b000000, 1'b0, 1'b0, TRAP, 1'b1, 2'b10);

    // Ready on the last allowed cycle wins over the timeout
    for (int i = 0; i < 15; i++) step(1'b0, 6'b000000, 1'b0, 1'b0, FETCH, 1'b0, 2'b00);
    step(1'b0, 6'b000000, 1'b1, 1'b0, FETCH, 1'b0, 2'b00);
    step(1'b0, 6'b000000, 1'b0, 1'b0, DECODE, 1'b0, 2'b00);
    step(1'b0, 6'b000000, 1'b0, 1'b0, R_EXEC, 1'b0, 2'b00);
    step(1'b0, 6'b000000, 1'b0, 1'b0, R_WB, 1'b0, 2'b00);
    step(1'b1, 6'b000000, 1'b0, 1'b0, FETCH, 1'b0, 2'b00);

    // Retire count over 2 R-type, lw, sw, j
    run_rtype();
    run_rtype();
    run_lw(0);
    run_sw();
    run_j();
`ifdef MIPS_CTRL_RETIRE_CNT_EN
    check("retired_five", retired, 32'd5);
`endif

    // Reset during MEM_WR: strobes drop at once, FETCH next cycle
    fetch(6'b101011);
    step(1'b0, 6'b101011, 1'b0, 1'b0, MEM_ADDR, 1'b0, 2'b00);
    step(1'b0, 6'b101011, 1'b0, 1'b0, MEM_WR, 1'b0, 2'b00);
    step(1'b1, 6'b101011, 1'b0, 1'b0, MEM_WR, 1'b0, 2'b00);
`ifdef MIPS_CTRL_RETIRE_CNT_EN
    check("retired_cleared", retired, 32'd0);
`endif
    step(1'b0, 6'b000000, 1'b0, 1'b0, FETCH, 1'b0, 2'b00);

    repeat (2) @(posedge clk);
    check("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
